// File: rtl/itl_ctrl_pkg.sv
// Shared constants and bank state type for the interleaver ping-pong buffer controller.
package itl_ctrl_pkg;

    localparam int ADDR_W  = 13;
    localparam int K_SMALL = 1056;
    localparam int K_LARGE = 6144;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

endpackage

// File: rtl/itl_blk_cnt.sv
// Loadable up-counter whose terminal flag marks the last index of a small or large block.
module itl_blk_cnt import itl_ctrl_pkg::*; #(
    parameter int ADDR_W  = itl_ctrl_pkg::ADDR_W,
    parameter int K_SMALL = itl_ctrl_pkg::K_SMALL,
    parameter int K_LARGE = itl_ctrl_pkg::K_LARGE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    input  logic              size,
    output logic [ADDR_W-1:0] cnt,
    output logic              term
);

    localparam logic [ADDR_W-1:0] LAST_SMALL = ADDR_W'(K_SMALL - 1);
    localparam logic [ADDR_W-1:0] LAST_LARGE = ADDR_W'(K_LARGE - 1);

    assign term = (cnt == (size ? LAST_LARGE : LAST_SMALL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/itl_pingpong_ctrl.sv
// Two-bank ping-pong controller: one writer fills a bank bit by bit while the reader
// drains the oldest full bank through the permutation-table index.
module itl_pingpong_ctrl import itl_ctrl_pkg::*; #(
    parameter int ADDR_W  = itl_ctrl_pkg::ADDR_W,
    parameter int K_SMALL = itl_ctrl_pkg::K_SMALL,
    parameter int K_LARGE = itl_ctrl_pkg::K_LARGE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blk_start,
    input  logic              blk_size,
    input  logic              bit_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_idx,
    output logic              rd_size,
    output logic              out_valid,
    output logic              out_last,
    output logic              blk_done,
    output logic              err_proto
);

    bank_state_t       bank_st  [2];
    bank_state_t       bank_nxt [2];
    logic [1:0]        bank_size, bank_size_nxt;
    logic              wr_busy, wr_busy_nxt, wr_sel, wr_sel_nxt;
    logic              rd_busy, rd_busy_nxt, rd_sel, rd_sel_nxt;
    logic              last_full, last_full_nxt;

    logic [ADDR_W-1:0] wr_cnt, rd_cnt;
    logic              wr_term, rd_term;
    logic              start_req, accept, fill_bank, wr_done;
    logic              full0, full1, drain_bank, rd_done, rd_start;

    // Readiness looks only at registered bank state, so a bank freed this cycle waits one cycle.
    assign in_ready  = !wr_busy && (bank_st[0] == BANK_EMPTY || bank_st[1] == BANK_EMPTY);
    assign start_req = blk_start && bit_valid;
    assign accept    = in_ready && start_req;
    assign err_proto = start_req && !in_ready;
    assign fill_bank = (bank_st[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
    assign wr_done   = wr_busy && bit_valid && wr_term;

    // Both banks can only be FULL together if the reader stalls; then the earlier one goes first.
    assign full0      = (bank_st[0] == BANK_FULL);
    assign full1      = (bank_st[1] == BANK_FULL);
    assign drain_bank = (full0 && full1) ? !last_full : full1;
    assign rd_done    = rd_busy && rd_term;
    assign rd_start   = (!rd_busy || rd_done) && (full0 || full1);

    assign wr_en   = accept || (wr_busy && bit_valid);
    assign wr_bank = accept ? fill_bank : wr_sel;
    assign wr_addr = wr_cnt;
    assign rd_en   = rd_busy;
    assign rd_bank = rd_sel;
    assign rd_idx  = rd_cnt;
    assign rd_size = rd_busy && bank_size[rd_sel];

    // The accept cycle writes address 0 itself, so the counter resumes at 1.
    itl_blk_cnt #(.ADDR_W(ADDR_W), .K_SMALL(K_SMALL), .K_LARGE(K_LARGE)) u_wr_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept || wr_done),
        .load_val (accept ? ADDR_W'(1) : '0),
        .inc      (wr_busy && bit_valid),
        .size     (bank_size[wr_sel]),
        .cnt      (wr_cnt),
        .term     (wr_term)
    );

    itl_blk_cnt #(.ADDR_W(ADDR_W), .K_SMALL(K_SMALL), .K_LARGE(K_LARGE)) u_rd_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (rd_done),
        .load_val ('0),
        .inc      (rd_busy),
        .size     (bank_size[rd_sel]),
        .cnt      (rd_cnt),
        .term     (rd_term)
    );

    // Writer and reader always touch different banks, so their updates never collide.
    always_comb begin
        bank_nxt      = bank_st;
        bank_size_nxt = bank_size;
        wr_busy_nxt   = wr_busy;
        wr_sel_nxt    = wr_sel;
        rd_busy_nxt   = rd_busy;
        rd_sel_nxt    = rd_sel;
        last_full_nxt = last_full;

        if (accept) begin
            bank_nxt[fill_bank]      = BANK_FILLING;
            bank_size_nxt[fill_bank] = blk_size;
            wr_busy_nxt              = 1'b1;
            wr_sel_nxt               = fill_bank;
        end
        if (wr_done) begin
            bank_nxt[wr_sel] = BANK_FULL;
            wr_busy_nxt      = 1'b0;
            last_full_nxt    = wr_sel;
        end
        if (rd_done) begin
            bank_nxt[rd_sel] = BANK_EMPTY;
            rd_busy_nxt      = 1'b0;
        end
        if (rd_start) begin
            bank_nxt[drain_bank] = BANK_DRAINING;
            rd_busy_nxt          = 1'b1;
            rd_sel_nxt           = drain_bank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            bank_size  <= '0;
            wr_busy    <= 1'b0;
            wr_sel     <= 1'b0;
            rd_busy    <= 1'b0;
            rd_sel     <= 1'b0;
            last_full  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            blk_done   <= 1'b0;
        end else begin
            bank_st    <= bank_nxt;
            bank_size  <= bank_size_nxt;
            wr_busy    <= wr_busy_nxt;
            wr_sel     <= wr_sel_nxt;
            rd_busy    <= rd_busy_nxt;
            rd_sel     <= rd_sel_nxt;
            last_full  <= last_full_nxt;
            out_valid  <= rd_busy;
            out_last   <= rd_done;
            blk_done   <= rd_done;
        end
    end

endmodule
